iterative_shift_extend_unit: RTL and testbench

//  Parametrised successor to the stage-4 shifter/extender. Multi-cycle barrel shifter
//  (SLL/SRL/SRA/ROL/ROR) shifting at most STEP bits per clock, plus registered zero-
//  and sign-extension of the instruction immediate. Sits beside the ALU in stage 4.

---
 rtl/shift_ext_pkg.sv | 31 +++
 rtl/iterative_shift_extend_unit_shift_step.sv | 38 +++
 rtl/iterative_shift_extend_unit.sv | 118 +++++++++++
 tb/tb_iterative_shift_extend_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/shift_ext_pkg.sv
// Shared types and helpers for the iterative shifter/extender.
//   modeT       : shift operation encoding (values 5-7 are illegal)
//   stateT      : sequencing FSM states
//   eff_amount  : effective shift distance for a requested mode/amount
package shift_ext_pkg;

  typedef enum logic [2:0] {
    MODE_SLL = 3'd0,
    MODE_SRL = 3'd1,
    MODE_SRA = 3'd2,
    MODE_ROL = 3'd3,
    MODE_ROR = 3'd4
  } modeT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } stateT;

  // Linear shifts saturate at the full width (result is all fill bits);
  // rotates only need the distance modulo the width. Illegal modes do nothing.
  function automatic int eff_amount(input logic [2:0] mode, input int shamt, input int width);
    case (mode)
      MODE_SLL, MODE_SRL, MODE_SRA: return (shamt > width) ? width : shamt;
      MODE_ROL, MODE_ROR:           return shamt % width;
      default:                      return 0;
    endcase
  endfunction

endpackage

// File: rtl/iterative_shift_extend_unit_shift_step.sv
// Combinational single-step shifter: shifts dataIn by amt (0..STEP) using mode.
//   mode    : operation (modeT encoding; illegal values pass dataIn through)
//   amt     : distance for this step, never larger than STEP
//   dataIn  : working value
//   dataOut : shifted value
// SRA uses the current MSB as fill; it equals the original operand MSB because
// an arithmetic right shift never changes the sign bit.
module shift_step
  import shift_ext_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  parameter int AMT_W = $clog2(STEP) + 1
) (
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut
);

  logic signed [WIDTH-1:0] dataInS;
  int                      amtI;

  always_comb begin
    dataInS = dataIn;
    amtI    = int'(amt);
    dataOut = dataIn;
    case (mode)
      MODE_SLL: dataOut = dataIn << amtI;
      MODE_SRL: dataOut = dataIn >> amtI;
      MODE_SRA: dataOut = dataInS >>> amtI;
      MODE_ROL: dataOut = (dataIn << amtI) | (dataIn >> (WIDTH - amtI));
      MODE_ROR: dataOut = (dataIn >> amtI) | (dataIn << (WIDTH - amtI));
      default:  dataOut = dataIn;
    endcase
  end

endmodule

// File: rtl/iterative_shift_extend_unit.sv
// Multi-cycle barrel shifter (SLL/SRL/SRA/ROL/ROR, at most STEP bits per clock)
// with registered zero/sign extension of the instruction immediate.
//   CLK        : clock, rising edge
//   CtrlRst    : asynchronous active-low reset
//   Start      : request, accepted when Ready=1
//   Mode       : 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5-7 illegal
//   ShAmt      : shift amount
//   ShifterIn  : operand
//   Imm        : immediate to extend
//   Ready      : high in IDLE and DONE
//   Done       : one-cycle pulse, ShifterOut valid
//   Illegal    : with Done, latched mode was 5-7
//   ShifterOut : result, held until next accept
//   ZeroExtOut : zero-extended Imm, registered at accept
//   SignExtOut : sign-extended Imm, registered at accept
module iterative_shift_extend_unit
  import shift_ext_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int IMM_W   = 12,
  parameter int STEP    = 4,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic               CLK,
  input  logic               CtrlRst,
  input  logic               Start,
  input  logic [2:0]         Mode,
  input  logic [SHAMT_W-1:0] ShAmt,
  input  logic [WIDTH-1:0]   ShifterIn,
  input  logic [IMM_W-1:0]   Imm,
  output logic               Ready,
  output logic               Done,
  output logic               Illegal,
  output logic [WIDTH-1:0]   ShifterOut,
  output logic [WIDTH-1:0]   ZeroExtOut,
  output logic [WIDTH-1:0]   SignExtOut
);

  localparam int AMT_W = $clog2(STEP) + 1;

  stateT              state, stateNext;
  logic               accept;
  logic [SHAMT_W-1:0] effNow;
  logic [SHAMT_W-1:0] rem;
  logic [AMT_W-1:0]   stepAmt;
  logic               lastStep;
  logic [2:0]         modeReg;
  logic [WIDTH-1:0]   workReg;
  logic [WIDTH-1:0]   stepOut;

  assign accept   = Start & Ready;
  assign effNow   = SHAMT_W'(eff_amount(Mode, int'(ShAmt), WIDTH));
  assign lastStep = (int'(rem) <= STEP);
  assign stepAmt  = lastStep ? rem[AMT_W-1:0] : AMT_W'(STEP);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AMT_W (AMT_W)
  ) uStep (
    .mode    (modeReg),
    .amt     (stepAmt),
    .dataIn  (workReg),
    .dataOut (stepOut)
  );

  // State register
  always_ff @(posedge CLK or negedge CtrlRst) begin
    if (!CtrlRst) state <= IDLE;
    else          state <= stateNext;
  end

  // Next-state logic; an accept from DONE chains directly into the next op
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = (effNow == '0) ? DONE : SHIFT;
      SHIFT:   if (lastStep) stateNext = DONE;
      DONE:    if (accept) stateNext = (effNow == '0) ? DONE : SHIFT;
               else        stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Ready   = (state != SHIFT);
    Done    = (state == DONE);
    Illegal = (state == DONE) && (modeReg > 3'd4);
  end

  // Control and visible result registers
  always_ff @(posedge CLK or negedge CtrlRst) begin
    if (!CtrlRst) begin
      rem        <= '0;
      modeReg    <= '0;
      ShifterOut <= '0;
      ZeroExtOut <= '0;
      SignExtOut <= '0;
    end else if (accept) begin
      rem        <= effNow;
      modeReg    <= Mode;
      ZeroExtOut <= {{(WIDTH-IMM_W){1'b0}}, Imm};
      SignExtOut <= {{(WIDTH-IMM_W){Imm[IMM_W-1]}}, Imm};
      if (effNow == '0) ShifterOut <= ShifterIn;
    end else if (state == SHIFT) begin
      rem <= rem - SHAMT_W'(stepAmt);
      if (lastStep) ShifterOut <= stepOut;
    end
  end

  // Working register: pure data, no reset needed since state gates its use
  always_ff @(posedge CLK) begin
    if (accept)              workReg <= ShifterIn;
    else if (state == SHIFT) workReg <= stepOut;
  end

endmodule

// File: tb/tb_iterative_shift_extend_unit.sv
module tb_iterative_shift_extend_unit;

  logic        CLK = 1'b0;
  logic        CtrlRst;
  logic        Start;
  logic [2:0]  Mode;
  logic [4:0]  ShAmt;
  logic [15:0] ShifterIn;
  logic [11:0] Imm;
  logic        Ready, Done, Illegal;
  logic [15:0] ShifterOut, ZeroExtOut, SignExtOut;

  int compared   = 0;
  int mismatched = 0;

  iterative_shift_extend_unit #(
    .WIDTH (16), .IMM_W (12), .STEP (4), .SHAMT_W (5)
  ) dut (
    .CLK        (CLK),
    .CtrlRst    (CtrlRst),
    .Start      (Start),
    .Mode       (Mode),
    .ShAmt      (ShAmt),
    .ShifterIn  (ShifterIn),
    .Imm        (Imm),
    .Ready      (Ready),
    .Done       (Done),
    .Illegal    (Illegal),
    .ShifterOut (ShifterOut),
    .ZeroExtOut (ZeroExtOut),
    .SignExtOut (SignExtOut)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, count edges (accept edge = 1) until Done.
  task automatic runOp(input string tag, input logic [2:0] m, input logic [4:0] sa,
                       input logic [15:0] din, input logic [11:0] im,
                       input int expEdges, input logic [15:0] expOut, input logic expIll);
    int edges;
    @(negedge CLK);
    Mode = m; ShAmt = sa; ShifterIn = din; Imm = im; Start = 1'b1;
    @(posedge CLK);
    edges = 1;
    @(negedge CLK);
    Start = 1'b0; Mode = m + 3'd1; ShAmt = ~sa; ShifterIn = ~din; Imm = ~im;
    if (expEdges > 1) check({tag, "_readyBusy"}, Ready, 0);
    while (!Done && edges < 40) begin
      @(posedge CLK);
      edges++;
      @(negedge CLK);
    end
    check({tag, "_edges"}, edges, expEdges);
    check({tag, "_out"}, ShifterOut, expOut);
    check({tag, "_illegal"}, Illegal, expIll);
  endtask

  initial begin
    CtrlRst = 1'b0; Start = 1'b0; Mode = 3'd0; ShAmt = 5'd0; ShifterIn = 16'h0; Imm = 12'h0;
    repeat (2) @(negedge CLK);
    check("rst_ready", Ready, 1);
    check("rst_done", Done, 0);
    check("rst_illegal", Illegal, 0);
    check("rst_out", ShifterOut, 0);
    check("rst_zext", ZeroExtOut, 0);
    check("rst_sext", SignExtOut, 0);
    CtrlRst = 1'b1;

    // Basic shifts and immediate extension
    runOp("sll5", 3'd0, 5'd5, 16'hFFF0, 12'h805, 3, 16'hFE00, 1'b0);
    check("sll5_zext", ZeroExtOut, 16'h0805);
    check("sll5_sext", SignExtOut, 16'hF805);
    @(negedge CLK);
    check("sll5_donePulse", Done, 0);
    check("sll5_readyIdle", Ready, 1);
    check("sll5_outHeld", ShifterOut, 16'hFE00);

    runOp("sra15", 3'd2, 5'd15, 16'h8000, 12'h07F, 5, 16'hFFFF, 1'b0);
    check("sra15_zext", ZeroExtOut, 16'h007F);
    check("sra15_sext", SignExtOut, 16'h007F);
    runOp("srl15", 3'd1, 5'd15, 16'h8000, 12'h000, 5, 16'h0001, 1'b0);
    runOp("ror20", 3'd4, 5'd20, 16'h1234, 12'h000, 2, 16'h4123, 1'b0);
    runOp("rol1",  3'd3, 5'd1,  16'h8001, 12'h000, 2, 16'h0003, 1'b0);

    // Bounds
    runOp("sll0",  3'd0, 5'd0,  16'hABCD, 12'h000, 1, 16'hABCD, 1'b0);
    runOp("sll31", 3'd0, 5'd31, 16'hFFFF, 12'h000, 5, 16'h0000, 1'b0);
    runOp("sra16", 3'd2, 5'd16, 16'h8000, 12'h000, 5, 16'hFFFF, 1'b0);

    // Start pulsed mid-SHIFT is ignored: SRL F000 by 12 -> 000F, Done at edge 4
    @(negedge CLK);
    Mode = 3'd1; ShAmt = 5'd12; ShifterIn = 16'hF000; Imm = 12'h000; Start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Mode = 3'd0; ShAmt = 5'd0; ShifterIn = 16'hAAAA;
    check("mid_ready1", Ready, 0);
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    check("mid_done2", Done, 0);
    check("mid_ready2", Ready, 0);
    @(posedge CLK);
    @(negedge CLK);
    check("mid_done3", Done, 0);
    @(posedge CLK);
    @(negedge CLK);
    check("mid_done4", Done, 1);
    check("mid_out", ShifterOut, 16'h000F);
    @(posedge CLK);
    @(negedge CLK);
    check("mid_noSecond", Done, 0);
    check("mid_outHeld", ShifterOut, 16'h000F);

    // Reset in the middle of SHIFT aborts the op
    Mode = 3'd0; ShAmt = 5'd15; ShifterIn = 16'hFFFF; Imm = 12'h123; Start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    @(posedge CLK);
    #2 CtrlRst = 1'b0;
    #1;
    check("arst_ready", Ready, 1);
    check("arst_done", Done, 0);
    check("arst_out", ShifterOut, 0);
    check("arst_zext", ZeroExtOut, 0);
    check("arst_sext", SignExtOut, 0);
    @(negedge CLK);
    CtrlRst = 1'b1;
    runOp("postRst", 3'd3, 5'd8, 16'h1234, 12'hFFF, 3, 16'h3412, 1'b0);
    check("postRst_sext", SignExtOut, 16'hFFFF);

    // Illegal mode, then back-to-back accept while in DONE
    @(negedge CLK);
    Mode = 3'd7; ShAmt = 5'd9; ShifterIn = 16'h1357; Imm = 12'h000; Start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("ill_done", Done, 1);
    check("ill_flag", Illegal, 1);
    check("ill_out", ShifterOut, 16'h1357);
    check("ill_ready", Ready, 1);
    Mode = 3'd0; ShAmt = 5'd0; ShifterIn = 16'h2468;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    check("b2b_done", Done, 1);
    check("b2b_flag", Illegal, 0);
    check("b2b_out", ShifterOut, 16'h2468);
    @(posedge CLK);
    @(negedge CLK);
    check("b2b_idle", Done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
